// File: rtl/n64_poll_scheduler.sv
// ---------------------------------------------------------------------------
// n64_poll_scheduler
//
// Sequences the N64 serial interface. It opens periodic poll windows,
// runs controller reset pulses, recovers from no-response timeouts, and
// latches every received 32-bit button word for the APB register block.
//
// Optional build macro: N64_CHANGE_DETECT_EN
//   defined   : data_valid pulses only when the new word differs from the
//               held one. The first frame after PRESERN or CRESET always pulses.
//   undefined : data_valid pulses on every completed frame.
//
// Ports
//   PCLK             in   clock
//   PRESERN          in   asynchronous active-low reset
//   sched_enable     in   level, enables periodic polling
//   period           in   poll period in PCLK cycles, sampled on POLL entry
//   reset_req        in   pulse, request a controller reset
//   err_clear        in   pulse, clears timeout_err and overrun
//   frame_done       in   pulse, button_data_in is valid
//   button_data_in   in   button word from the serial interface
//   polling_enable   out  high throughout POLL
//   controller_reset out  high throughout CRESET
//   button_data      out  last latched button word
//   data_valid       out  one-cycle pulse when button_data updates
//   frame_count      out  completed frame count, wraps
//   timeout_err      out  sticky no-response flag
//   overrun          out  sticky, the period expired while in POLL
//   busy             out  high in POLL or CRESET
// ---------------------------------------------------------------------------
module n64_poll_scheduler #(
   parameter int PERIOD_W       = 24,
   parameter int TIMEOUT_CYCLES = 30000,
   parameter int RESET_HOLD     = 100,
   parameter int MIN_PERIOD     = 16
) (
   input  logic                PCLK,
   input  logic                PRESERN,
   input  logic                sched_enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic                reset_req,
   input  logic                err_clear,
   input  logic                frame_done,
   input  logic [31:0]         button_data_in,
   output logic                polling_enable,
   output logic                controller_reset,
   output logic [31:0]         button_data,
   output logic                data_valid,
   output logic [15:0]         frame_count,
   output logic                timeout_err,
   output logic                overrun,
   output logic                busy
);

   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int HOLD_W = $clog2(RESET_HOLD + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_POLL   = 2'd2,
      S_CRESET = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
   logic [PERIOD_W-1:0] eff_period, reload_val;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                pending_q, pending_d;
   logic                polling_enable_q, controller_reset_q, busy_q;
   logic                data_valid_q, timeout_err_q, overrun_q;
   logic [31:0]         button_data_q;
   logic [15:0]         frame_count_q;
   logic                latch, set_to, set_ov, dv_d;
   logic                period_expired, timeout_hit, hold_done, reset_wanted;
   logic                poll_entry, creset_entry, creset_exit;
`ifdef N64_CHANGE_DETECT_EN
   logic                seen_q, seen_d;
`endif

   always_comb begin
      eff_period     = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
      reload_val     = eff_period - PERIOD_W'(1);
      period_expired = (per_cnt_q == '0);
      timeout_hit    = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
      hold_done      = (hold_cnt_q == HOLD_W'(RESET_HOLD - 1));
      reset_wanted   = pending_q | reset_req;

      state_d   = state_q;
      pending_d = pending_q;
      latch     = 1'b0;
      set_to    = 1'b0;
      set_ov    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (reset_req)         state_d = S_CRESET;
            else if (sched_enable) state_d = S_POLL;
         end
         S_WAIT: begin
            if (reset_req)           state_d = S_CRESET;
            else if (!sched_enable)  state_d = S_IDLE;
            else if (period_expired) state_d = S_POLL;
         end
         S_POLL: begin
            set_ov    = period_expired;
            // A reset request mid-transaction is deferred until POLL exits.
            pending_d = reset_wanted;
            if (frame_done) begin
               latch = 1'b1;
               if (reset_wanted)                       state_d = S_CRESET;
               else if (period_expired && sched_enable) state_d = S_POLL;
               else                                     state_d = S_WAIT;
            end else if (timeout_hit) begin
               set_to  = 1'b1;
               state_d = S_CRESET;
            end
         end
         default: begin
            if (hold_done) state_d = sched_enable ? S_WAIT : S_IDLE;
         end
      endcase

      // Back-to-back POLL after an overrun is a fresh entry as well.
      poll_entry   = (state_d == S_POLL) && ((state_q != S_POLL) || latch);
      creset_entry = (state_d == S_CRESET) && (state_q != S_CRESET);
      creset_exit  = (state_q == S_CRESET) && (state_d != S_CRESET);

      if (creset_entry) pending_d = 1'b0;

      per_cnt_d = per_cnt_q;
      if (poll_entry || creset_exit)
         per_cnt_d = reload_val;
      else if (((state_q == S_WAIT) || (state_q == S_POLL)) && !period_expired)
         per_cnt_d = per_cnt_q - PERIOD_W'(1);

      to_cnt_d = to_cnt_q;
      if (poll_entry)             to_cnt_d = '0;
      else if (state_q == S_POLL) to_cnt_d = to_cnt_q + TO_W'(1);

      hold_cnt_d = hold_cnt_q;
      if (creset_entry)             hold_cnt_d = '0;
      else if (state_q == S_CRESET) hold_cnt_d = hold_cnt_q + HOLD_W'(1);

`ifdef N64_CHANGE_DETECT_EN
      dv_d   = latch & (~seen_q | (button_data_in != button_data_q));
      seen_d = seen_q;
      if (latch)        seen_d = 1'b1;
      // Entering CRESET forgets history, even on the frame that triggered it.
      if (creset_entry) seen_d = 1'b0;
`else
      dv_d = latch;
`endif
   end

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         state_q            <= S_IDLE;
         per_cnt_q          <= '0;
         to_cnt_q           <= '0;
         hold_cnt_q         <= '0;
         pending_q          <= 1'b0;
         polling_enable_q   <= 1'b0;
         controller_reset_q <= 1'b0;
         busy_q             <= 1'b0;
         data_valid_q       <= 1'b0;
         timeout_err_q      <= 1'b0;
         overrun_q          <= 1'b0;
         button_data_q      <= '0;
         frame_count_q      <= '0;
`ifdef N64_CHANGE_DETECT_EN
         seen_q             <= 1'b0;
`endif
      end else begin
         state_q            <= state_d;
         per_cnt_q          <= per_cnt_d;
         to_cnt_q           <= to_cnt_d;
         hold_cnt_q         <= hold_cnt_d;
         pending_q          <= pending_d;
         polling_enable_q   <= (state_d == S_POLL);
         controller_reset_q <= (state_d == S_CRESET);
         busy_q             <= (state_d == S_POLL) || (state_d == S_CRESET);
         data_valid_q       <= dv_d;
         // Setting a flag takes precedence over clearing it in the same cycle.
         timeout_err_q      <= (timeout_err_q & ~err_clear) | set_to;
         overrun_q          <= (overrun_q & ~err_clear) | set_ov;
         if (latch) begin
            button_data_q <= button_data_in;
            frame_count_q <= frame_count_q + 16'd1;
         end
`ifdef N64_CHANGE_DETECT_EN
         seen_q             <= seen_d;
`endif
      end
   end

   assign polling_enable   = polling_enable_q;
   assign controller_reset = controller_reset_q;
   assign busy             = busy_q;
   assign data_valid       = data_valid_q;
   assign timeout_err      = timeout_err_q;
   assign overrun          = overrun_q;
   assign button_data      = button_data_q;
   assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Testbench for n64_poll_scheduler: directed scenarios plus a random run,
// all compared cycle by cycle against a time-since-anchor reference model.
module tb_n64_poll_scheduler;

   localparam int PW   = 24;
   localparam int TO   = 50;
   localparam int RH   = 10;
   localparam int MINP = 16;

   localparam int ST_IDLE   = 0;
   localparam int ST_WAIT   = 1;
   localparam int ST_POLL   = 2;
   localparam int ST_CRESET = 3;

   logic          PCLK = 1'b0;
   logic          PRESERN = 1'b0;
   logic          sched_enable = 1'b0;
   logic [PW-1:0] period = '0;
   logic          reset_req = 1'b0;
   logic          err_clear = 1'b0;
   logic          frame_done = 1'b0;
   logic [31:0]   button_data_in = '0;
   logic          polling_enable, controller_reset, data_valid;
   logic          timeout_err, overrun, busy;
   logic [31:0]   button_data;
   logic [15:0]   frame_count;

   always #5 PCLK = ~PCLK;

   n64_poll_scheduler #(
      .PERIOD_W(PW), .TIMEOUT_CYCLES(TO), .RESET_HOLD(RH), .MIN_PERIOD(MINP)
   ) dut (
      .PCLK(PCLK), .PRESERN(PRESERN), .sched_enable(sched_enable), .period(period),
      .reset_req(reset_req), .err_clear(err_clear), .frame_done(frame_done),
      .button_data_in(button_data_in), .polling_enable(polling_enable),
      .controller_reset(controller_reset), .button_data(button_data),
      .data_valid(data_valid), .frame_count(frame_count),
      .timeout_err(timeout_err), .overrun(overrun), .busy(busy)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model: period expiry is "cycles since the last anchor
   // (POLL entry or CRESET exit) reached the effective period".
   int          m_state, m_since, m_plen, m_in_poll, m_in_reset, m_fc;
   bit          m_pending, m_seen, m_dv, m_to, m_ov;
   logic [31:0] m_data;

   // Observations of the DUT used by the directed checks.
   int          rise_q[$];
   int          pe_run, last_pe_len, cr_run, last_cr_len, cr_rise_cyc;
   int          dv_count;
   bit          pe_prev, cr_prev, pe_at_dv;
   logic [31:0] data_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", tag, cyc, got, exp);
      end
   endtask

   function automatic int eff_len(input int p);
      return (p < MINP) ? MINP : p;
   endfunction

   task automatic model_reset();
      m_state = ST_IDLE; m_since = 0; m_plen = 0; m_in_poll = 0; m_in_reset = 0;
      m_fc = 0; m_pending = 0; m_seen = 0; m_dv = 0; m_to = 0; m_ov = 0; m_data = '0;
   endtask

   task automatic model_step();
      int nxt;
      bit frame, set_to, set_ov, expired;
      nxt = m_state; frame = 0; set_to = 0; set_ov = 0;
      expired = (m_since >= m_plen - 1);
      m_dv = 0;
      case (m_state)
         ST_IDLE: begin
            if (reset_req) nxt = ST_CRESET;
            else if (sched_enable) nxt = ST_POLL;
         end
         ST_WAIT: begin
            if (reset_req) nxt = ST_CRESET;
            else if (!sched_enable) nxt = ST_IDLE;
            else if (expired) nxt = ST_POLL;
         end
         ST_POLL: begin
            set_ov = expired;
            if (frame_done) begin
               frame = 1;
               if (m_pending || reset_req) nxt = ST_CRESET;
               else if (expired && sched_enable) nxt = ST_POLL;
               else nxt = ST_WAIT;
            end else if (m_in_poll == TO - 1) begin
               set_to = 1;
               nxt = ST_CRESET;
            end else if (reset_req) begin
               m_pending = 1;
            end
         end
         default: begin
            if (m_in_reset == RH - 1) nxt = sched_enable ? ST_WAIT : ST_IDLE;
         end
      endcase
      if (frame) begin
`ifdef N64_CHANGE_DETECT_EN
         m_dv = !m_seen || (button_data_in != m_data);
`else
         m_dv = 1;
`endif
         m_data = button_data_in;
         m_fc = (m_fc + 1) & 32'hFFFF;
         m_seen = 1;
      end
      if (nxt == ST_POLL && (m_state != ST_POLL || frame)) begin
         m_since = 0; m_plen = eff_len(int'(period)); m_in_poll = 0;
      end else if (m_state == ST_CRESET && nxt != ST_CRESET) begin
         m_since = 0; m_plen = eff_len(int'(period));
      end else begin
         if (m_state == ST_WAIT || m_state == ST_POLL) m_since++;
         if (m_state == ST_POLL) m_in_poll++;
      end
      if (nxt == ST_CRESET && m_state != ST_CRESET) begin
         m_in_reset = 0; m_pending = 0; m_seen = 0;
      end else if (m_state == ST_CRESET) begin
         m_in_reset++;
      end
      m_to = (m_to && !err_clear) || set_to;
      m_ov = (m_ov && !err_clear) || set_ov;
      m_state = nxt;
   endtask

   task automatic compare_outputs();
      check_eq("polling_enable", 32'(polling_enable), 32'(m_state == ST_POLL));
      check_eq("controller_reset", 32'(controller_reset), 32'(m_state == ST_CRESET));
      check_eq("busy", 32'(busy), 32'(m_state == ST_POLL || m_state == ST_CRESET));
      check_eq("button_data", button_data, m_data);
      check_eq("data_valid", 32'(data_valid), 32'(m_dv));
      check_eq("frame_count", 32'(frame_count), 32'(m_fc));
      check_eq("timeout_err", 32'(timeout_err), 32'(m_to));
      check_eq("overrun", 32'(overrun), 32'(m_ov));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_pe"}, 32'(polling_enable), 32'd0);
      check_eq({tag, "_cr"}, 32'(controller_reset), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_data"}, button_data, 32'd0);
      check_eq({tag, "_dv"}, 32'(data_valid), 32'd0);
      check_eq({tag, "_fc"}, 32'(frame_count), 32'd0);
      check_eq({tag, "_to"}, 32'(timeout_err), 32'd0);
      check_eq({tag, "_ov"}, 32'(overrun), 32'd0);
   endtask

   task automatic observe();
      if (polling_enable && !pe_prev) rise_q.push_back(cyc);
      if (polling_enable) pe_run++;
      else if (pe_prev) begin last_pe_len = pe_run; pe_run = 0; end
      if (controller_reset && !cr_prev) cr_rise_cyc = cyc;
      if (controller_reset) cr_run++;
      else if (cr_prev) begin last_cr_len = cr_run; cr_run = 0; end
      if (data_valid) begin dv_count++; pe_at_dv = polling_enable; end
      pe_prev = polling_enable;
      cr_prev = controller_reset;
   endtask

   // Inputs are applied just after a falling edge, consumed at the next
   // rising edge, and the outputs are compared at the following falling edge.
   task automatic tick(input bit se, input int per, input bit rr, input bit clr,
                       input bit fd, input logic [31:0] din);
      sched_enable = se; period = PW'(per); reset_req = rr;
      err_clear = clr; frame_done = fd; button_data_in = din;
      model_step();
      @(negedge PCLK);
      cyc++;
      compare_outputs();
      observe();
   endtask

   task automatic run_phase(input int n, input bit se, input int per,
                            input int fd_at, input int rr_at);
      bit fd, rr;
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         fd = (m_state == ST_POLL) && (m_in_poll == fd_at);
         rr = (rr_at >= 0) && (m_state == ST_POLL) && (m_in_poll == rr_at);
         d = $urandom();
         if (fd && data_q.size() > 0) d = data_q.pop_front();
         tick(se, per, rr, 1'b0, fd, d);
      end
   endtask

   task automatic clear_obs();
      rise_q.delete(); dv_count = 0; pe_at_dv = 0;
   endtask

   initial begin
      bit se_r, rr, clr, fd;
      int per_r, cd_expect;
      logic [31:0] d;
      model_reset();
      pe_run = 0; last_pe_len = 0; cr_run = 0; last_cr_len = 0; cr_rise_cyc = 0;
      pe_prev = 0; cr_prev = 0; clear_obs();

      // Power-on reset, then idle with polling disabled.
      @(negedge PCLK);
      check_all_zero("por");
      PRESERN = 1'b1;
      run_phase(5, 0, 100, -1, -1);

      // Periodic polling, period 100, frames 20 cycles into each POLL.
      clear_obs();
      data_q.push_back(32'h12345678);
      data_q.push_back(32'h0000F00F);
      run_phase(205, 1, 100, 20, -1);
      check_eq("periodic_rises", rise_q.size(), 3);
      if (rise_q.size() >= 3) begin
         check_eq("periodic_gap1", rise_q[1] - rise_q[0], 100);
         check_eq("periodic_gap2", rise_q[2] - rise_q[1], 100);
      end
      check_eq("periodic_dv_count", dv_count, 2);
      check_eq("periodic_fc", 32'(frame_count), 32'd2);
      check_eq("periodic_data", button_data, 32'h0000F00F);
      run_phase(40, 0, 100, 20, -1);

      // Timeout: no frame_done at all.
      run_phase(70, 1, 100, -1, -1);
      check_eq("timeout_pe_len", last_pe_len, TO);
      check_eq("timeout_cr_len", last_cr_len, RH);
      check_eq("timeout_err_set", 32'(timeout_err), 32'd1);
      tick(0, 100, 0, 1, 0, 32'h0);
      check_eq("timeout_err_clr", 32'(timeout_err), 32'd0);
      run_phase(3, 0, 100, -1, -1);

      // Deferred reset: request 5 cycles into POLL, frame at 20.
      clear_obs();
      data_q.push_back(32'hAAAA5555);
      run_phase(40, 1, 100, 20, 5);
      check_eq("defer_data", button_data, 32'hAAAA5555);
      check_eq("defer_dv_count", dv_count, 1);
      check_eq("defer_pe_len", last_pe_len, 21);
      check_eq("defer_cr_len", last_cr_len, RH);
      if (rise_q.size() >= 1) check_eq("defer_cr_start", cr_rise_cyc - rise_q[0], 21);
      run_phase(3, 0, 100, -1, -1);

      // Overrun: period 30, frame at 40 -> back-to-back POLL.
      clear_obs();
      run_phase(45, 1, 30, 40, -1);
      check_eq("overrun_set", 32'(overrun), 32'd1);
      check_eq("overrun_dv_count", dv_count, 1);
      check_eq("overrun_direct_poll", 32'(pe_at_dv), 32'd1);
      run_phase(60, 0, 30, 40, -1);
      tick(0, 30, 0, 1, 0, 32'h0);
      check_eq("overrun_clr", 32'(overrun), 32'd0);

      // Clamp: period 3 behaves as 16.
      clear_obs();
      run_phase(50, 1, 3, 2, -1);
      check_eq("clamp_rises", rise_q.size(), 4);
      if (rise_q.size() >= 3) begin
         check_eq("clamp_gap1", rise_q[1] - rise_q[0], 16);
         check_eq("clamp_gap2", rise_q[2] - rise_q[1], 16);
      end
      run_phase(20, 0, 3, 2, -1);

      // Asynchronous reset in the middle of POLL with inputs toggling.
      run_phase(8, 1, 50, -1, -1);
      sched_enable = 1; reset_req = 1; err_clear = 1; frame_done = 1;
      button_data_in = $urandom();
      #2 PRESERN = 1'b0;
      #1 check_all_zero("rst_async");
      for (int i = 0; i < 2; i++) begin
         @(negedge PCLK);
         cyc++;
         frame_done = ~frame_done; reset_req = ~reset_req; button_data_in = $urandom();
         check_all_zero("rst_hold");
      end
      model_reset();
      pe_prev = 0; cr_prev = 0; pe_run = 0; cr_run = 0;
      sched_enable = 0; reset_req = 0; err_clear = 0; frame_done = 0;
      PRESERN = 1'b1;
      run_phase(5, 0, 50, -1, -1);

      // Frames 0x1, 0x1, 0x2 right after reset.
      clear_obs();
      data_q.push_back(32'h1);
      data_q.push_back(32'h1);
      data_q.push_back(32'h2);
      run_phase(58, 1, 20, 5, -1);
`ifdef N64_CHANGE_DETECT_EN
      cd_expect = 2;
`else
      cd_expect = 3;
`endif
      check_eq("cd_dv_count", dv_count, cd_expect);
      check_eq("cd_fc", 32'(frame_count), 32'd3);
      check_eq("cd_data", button_data, 32'h2);
      run_phase(5, 0, 20, 5, -1);

      // Random traffic against the model.
      se_r = 1; per_r = 20;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) se_r = ~se_r;
         if ($urandom_range(0, 49) == 0) per_r = $urandom_range(0, 40);
         rr  = ($urandom_range(0, 199) == 0);
         clr = ($urandom_range(0, 39) == 0);
         fd  = ($urandom_range(0, 24) == 0);
         case ($urandom_range(0, 2))
            0: d = 32'h1;
            1: d = 32'h2;
            default: d = $urandom();
         endcase
         tick(se_r, per_r, rr, clr, fd, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/n64_poll_scheduler.md
Name: n64_poll_scheduler

Overview:
- Sequences the N64 serial interface: issues periodic poll windows (polling_enable), runs controller reset pulses (controller_reset), and recovers from no-response timeouts.
- Latches each received 32-bit button word for the APB register block.
- Sits between the APB interface (configuration and commands) and the serial interface (transaction engine), all on PCLK.

Parameters:
- PERIOD_W, 24, width of the poll period register.
- TIMEOUT_CYCLES, 30000, PCLK cycles in POLL without frame_done before a timeout is declared.
- RESET_HOLD, 100, PCLK cycles that controller_reset is held high.
- MIN_PERIOD, 16, smallest period honoured; smaller period values are clamped up to this.

Ports:
- PCLK  in  1  clock.
- PRESERN  in  1  asynchronous active-low reset.
- sched_enable  in  1  level; enables periodic polling.
- period  in  PERIOD_W  poll period in PCLK cycles, sampled on each POLL entry.
- reset_req  in  1  one-cycle pulse; request a controller reset.
- err_clear  in  1  one-cycle pulse; clears timeout_err and overrun.
- frame_done  in  1  one-cycle pulse from the serial interface; button_data_in is valid.
- button_data_in  in  32  button word from the serial interface.
- polling_enable  out  1  high throughout POLL.
- controller_reset  out  1  high throughout CRESET.
- button_data  out  32  last latched button word.
- data_valid  out  1  one-cycle pulse when button_data updates.
- frame_count  out  16  count of completed frames; wraps 0xFFFF to 0.
- timeout_err  out  1  sticky.
- overrun  out  1  sticky; a period expired while in POLL.
- busy  out  1  high in POLL or CRESET.

Behaviour:
- Reset: PRESERN low asynchronously forces state IDLE and clears every output, counter, and pending flag to 0.
- Assertion at any point, including mid-POLL, abandons the transaction with no data latched.
- States: IDLE, WAIT, POLL, CRESET.
- IDLE:
  - reset_req goes to CRESET (this has priority).
  - Otherwise, sched_enable=1 goes to POLL on the next cycle.
- POLL entry:
  - Load the period counter with max(period, MIN_PERIOD)-1.
  - Clear the timeout counter.
  - The period counter decrements every cycle outside IDLE and CRESET, stopping at 0.
- POLL:
  - polling_enable=1.
  - On frame_done: latch button_data_in, pulse data_valid the following cycle, increment frame_count, then go to WAIT.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without frame_done: set timeout_err, go to CRESET. Nothing is latched and frame_count is unchanged.
  - frame_done and timeout in the same cycle: frame_done wins.
  - sched_enable falling during POLL does not abort; the transaction completes or times out first.
- WAIT:
  - sched_enable=0 goes to IDLE.
  - reset_req goes to CRESET.
  - When the period counter reaches 0, go to POLL.
  - reset_req and period expiry in the same cycle: CRESET wins.
  - Without disturbances, POLL entries are exactly max(period, MIN_PERIOD) cycles apart.
- Overrun:
  - If the period counter reaches 0 while in POLL, set overrun.
  - On the subsequent frame_done, go directly to POLL (skipping WAIT) if sched_enable=1.
- reset_req during POLL: recorded in a pending flag. On leaving POLL (either exit), go to CRESET instead of WAIT. The pending flag clears on CRESET entry.
- CRESET:
  - controller_reset=1 for exactly RESET_HOLD cycles.
  - Then go to WAIT if sched_enable=1, else IDLE.
  - The period counter is reloaded with max(period, MIN_PERIOD)-1 on CRESET exit.
  - reset_req during CRESET is ignored.
- err_clear:
  - Clears timeout_err and overrun next cycle.
  - If the same cycle also sets either flag, set wins.
- busy = (state==POLL) or (state==CRESET).
- All outputs are registered.

Optional Feature:
- Macro: N64_CHANGE_DETECT_EN.
- Defined:
  - data_valid pulses only when the frame's button_data_in differs from the currently held button_data.
  - The first frame after PRESERN or after CRESET always pulses.
  - button_data and frame_count update on every frame regardless.
- Undefined: data_valid pulses on every completed frame.

Test Plan:
- Reset: drive PRESERN low mid-POLL with inputs toggling -> all outputs 0, state IDLE; after release, no polling_enable until sched_enable=1.
- Periodic poll:
  - Stimulus: period=100, sched_enable=1, frame_done 20 cycles after each polling_enable rise, data 0x12345678 then 0x0000F00F.
  - Required: polling_enable rises every 100 cycles; data_valid pulses once per frame; button_data follows the data; frame_count=1, then 2.
- Timeout (TIMEOUT_CYCLES=50, RESET_HOLD=10): no frame_done -> polling_enable drops after 50 cycles, timeout_err=1, controller_reset high exactly 10 cycles, then WAIT; err_clear -> timeout_err=0.
- Deferred reset:
  - Stimulus: reset_req 5 cycles into POLL, frame_done at cycle 20 with 0xAAAA5555.
  - Required: data latched, frame_count increments, then controller_reset high 10 cycles; no reset pulse before frame_done.
- Overrun and clamp:
  - Stimulus 1: period=30, frame_done after 40 cycles -> overrun=1 and the next POLL starts the cycle after WAIT would have been entered (no WAIT).
  - Stimulus 2: period=3 -> POLL entries 16 cycles apart.
- Change detect (macro defined): three frames 0x1, 0x1, 0x2 -> data_valid pulses on frames 1 and 3 only; frame_count=3.
